irq_controller: RTL and testbench

//  Collects external hardware IRQ lines, the Count/Compare timer and Cause.IP[1:0] software bits.

---
 rtl/irq_controller_if.sv | 31 +++
 rtl/irq_controller.sv | 118 +++++++++++
 tb/tb_irq_controller.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - interrupt source/mask inputs and CPU-facing request outputs
interface irq_controller_if #(
    parameter int NUM_IRQ = 6
);
    logic               stall;
    logic [NUM_IRQ-1:0] irqIn;
    logic [NUM_IRQ-1:0] irqEdge;
    logic [NUM_IRQ-1:0] irqClr;
    logic               timerIrq;
    logic [1:0]         swIP;
    logic [7:0]         statusIM;
    logic               statusIE;
    logic               statusEXL;
    logic               statusERL;
    logic               intAck;
    logic               interrupt;
    logic [7:0]         causeIP;
    logic [2:0]         irqId;

    modport master (
        output stall, irqIn, irqEdge, irqClr, timerIrq, swIP,
               statusIM, statusIE, statusEXL, statusERL, intAck,
        input  interrupt, causeIP, irqId
    );

    modport slave (
        input  stall, irqIn, irqEdge, irqClr, timerIrq, swIP,
               statusIM, statusIE, statusEXL, statusERL, intAck,
        output interrupt, causeIP, irqId
    );
endinterface

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - synchronises, latches and masks IRQ sources into one interrupt request
module irq_controller #(
    parameter int NUM_IRQ     = 6,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_MAX = 7
) (
    input logic              clk,
    input logic              rst,
    irq_controller_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] s;
    logic [7:0]         cause_q;
    logic [7:0]         en;
    logic [2:0]         id_q;
    logic [2:0]         id_d;
    logic               int_req;
    logic               int_q;
    state_t             state_q;
    state_t             state_d;
    logic [2:0]         cnt_q;
    logic [2:0]         cnt_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Edge lines: a fresh edge wins over a simultaneous clear.
    always_comb begin
        pend_d = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.irqEdge[i])
                pend_d[i] = (s[i] & ~prev_q[i]) | (pend_q[i] & ~bus.irqClr[i]);
            else
                pend_d[i] = s[i];
        end
    end

    assign en      = cause_q & bus.statusIM;
    assign int_req = (|en) & bus.statusIE & ~bus.statusEXL & ~bus.statusERL;

    always_comb begin
        id_d = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (en[i])
                id_d = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++)
                sync_q[k] <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            cause_q <= 8'd0;
            id_q    <= 3'd0;
        end else begin
            sync_q[0] <= bus.irqIn;
            for (int k = 1; k < SYNC_STAGES; k++)
                sync_q[k] <= sync_q[k-1];
            prev_q  <= s;
            pend_q  <= pend_d;
            cause_q <= {pend_q[5] | bus.timerIrq, pend_q[4:0], bus.swIP};
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.stall) begin
            case (state_q)
                IDLE: begin
                    if (int_req)
                        state_d = ASSERT;
                end
                ASSERT: begin
                    if (bus.intAck) begin
                        state_d = HOLDOFF;
                        cnt_d   = 3'd0;
                    end else if (!int_req) begin
                        state_d = IDLE;
                    end
                end
                HOLDOFF: begin
                    // Hold off until EXL/ERL is visible so the same source is not taken twice.
                    if (bus.statusEXL || bus.statusERL || cnt_q == 3'(HOLDOFF_MAX)) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            int_q   <= (state_d == ASSERT);
        end
    end

    assign bus.interrupt = int_q;
    assign bus.causeIP   = cause_q;
    assign bus.irqId     = id_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - scoreboard bench for irq_controller with a reference model
module tb_irq_controller;
    localparam int NUM_IRQ     = 6;
    localparam int SYNC_STAGES = 2;
    localparam int HOLDOFF_MAX = 7;

    logic clk = 1'b0;
    logic rst = 1'b0;
    irq_controller_if #(.NUM_IRQ(NUM_IRQ)) bus ();

    irq_controller #(
        .NUM_IRQ(NUM_IRQ), .SYNC_STAGES(SYNC_STAGES), .HOLDOFF_MAX(HOLDOFF_MAX)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [11:0]        exp_q [$];
    logic [NUM_IRQ-1:0] m_hist [$];
    logic [NUM_IRQ-1:0] m_pend;
    logic [7:0]         m_cause;
    logic [2:0]         m_id;
    int                 m_mode;   // 0 idle, 1 requesting, 2 holding off
    int                 m_cnt;
    logic               m_int;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_clear();
        m_hist.delete();
        for (int k = 0; k <= SYNC_STAGES; k++) m_hist.push_back('0);
        m_pend = '0; m_cause = '0; m_id = '0; m_mode = 0; m_cnt = 0; m_int = 1'b0;
    endfunction

    function automatic void model_step();
        logic [NUM_IRQ-1:0] s, p, np;
        logic [7:0] nc, en;
        int nid;
        bit req;
        if (!rst) begin
            model_clear();
            return;
        end
        s = m_hist[SYNC_STAGES-1];
        p = m_hist[SYNC_STAGES];
        for (int i = 0; i < NUM_IRQ; i++)
            np[i] = bus.irqEdge[i] ? ((s[i] && !p[i]) || (m_pend[i] && !bus.irqClr[i])) : s[i];
        nc  = {m_pend[5] | bus.timerIrq, m_pend[4:0], bus.swIP};
        en  = m_cause & bus.statusIM;
        nid = 0;
        for (int i = 0; i < 8; i++) if (en[i]) nid = i;
        req = (en != 0) && bus.statusIE && !bus.statusEXL && !bus.statusERL;
        if (!bus.stall) begin
            if (m_mode == 0) begin
                if (req) m_mode = 1;
            end else if (m_mode == 1) begin
                if (bus.intAck) begin m_mode = 2; m_cnt = 0; end
                else if (!req) m_mode = 0;
            end else begin
                if (bus.statusEXL || bus.statusERL || m_cnt == HOLDOFF_MAX) m_mode = 0;
                else m_cnt++;
            end
        end
        m_hist.push_front(bus.irqIn);
        void'(m_hist.pop_back());
        m_pend = np; m_cause = nc; m_id = nid[2:0]; m_int = (m_mode == 1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        exp_q.push_back({m_int, m_cause, m_id});
    endtask

    // Monitor: one output set per cycle, compared against the oldest prediction.
    always @(negedge clk) begin
        logic [11:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_interrupt", 32'(bus.interrupt), 32'(e[11]));
            check("sb_causeIP",   32'(bus.causeIP),   32'(e[10:3]));
            check("sb_irqId",     32'(bus.irqId),     32'(e[2:0]));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int zeros;
        int waited;
        model_clear();
        bus.stall = 0; bus.irqIn = '0; bus.irqEdge = '0; bus.irqClr = '0;
        bus.timerIrq = 0; bus.swIP = 2'b00; bus.statusIM = 8'h00;
        bus.statusIE = 0; bus.statusEXL = 0; bus.statusERL = 0; bus.intAck = 0;
        rst = 0;
        step(); step();
        check("reset_interrupt", 32'(bus.interrupt), 32'd0);
        check("reset_causeIP",   32'(bus.causeIP),   32'd0);
        check("reset_irqId",     32'(bus.irqId),     32'd0);
        rst = 1;
        step();

        // Level line 2 -> Cause.IP[4]
        bus.statusIM = 8'h10; bus.statusIE = 1;
        bus.irqIn = 6'b000100;
        step(); step(); step();
        check("lvl_cause_t2", 32'(bus.causeIP), 32'h00);
        step();
        check("lvl_cause_t3", 32'(bus.causeIP), 32'h10);
        check("lvl_int_t3",   32'(bus.interrupt), 32'd0);
        step();
        check("lvl_int_t4", 32'(bus.interrupt), 32'd1);
        check("lvl_id_t4",  32'(bus.irqId), 32'd4);
        bus.intAck = 1;
        step();
        check("ack_drop", 32'(bus.interrupt), 32'd0);
        bus.intAck = 0; bus.statusEXL = 1;
        step(); step();
        check("exl_idle", 32'(bus.interrupt), 32'd0);

        // Holdoff expiry without EXL
        bus.statusEXL = 0;
        waited = 0;
        while (bus.interrupt !== 1'b1 && waited < 10) begin step(); waited++; end
        check("reassert_wait", 32'(bus.interrupt), 32'd1);
        bus.intAck = 1;
        step();
        bus.intAck = 0;
        zeros = 0;
        step();
        while (bus.interrupt === 1'b0 && zeros < 20) begin zeros++; step(); end
        check("holdoff_len", 32'(zeros), 32'(HOLDOFF_MAX + 1));

        // Reset while requesting
        rst = 0;
        step();
        check("rst_int",   32'(bus.interrupt), 32'd0);
        check("rst_cause", 32'(bus.causeIP),   32'd0);
        rst = 1;
        bus.irqIn = '0; bus.statusIM = 8'h00;
        step();

        // Edge line 0 -> Cause.IP[2], clear latched bit
        bus.irqEdge = 6'b000001;
        bus.irqIn = 6'b000001; step();
        bus.irqIn = 6'b000000;
        for (int k = 0; k < 6; k++) step();
        check("edge_latched", 32'(bus.causeIP[2]), 32'd1);
        bus.irqClr = 6'b000001; step();
        bus.irqClr = 6'b000000; step();
        check("edge_cleared", 32'(bus.causeIP[2]), 32'd0);

        // Randomised traffic
        for (int c = 0; c < 4000; c++) begin
            rst          = ($urandom_range(0, 149) != 0);
            bus.stall    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) bus.irqIn = 6'($urandom);
            bus.irqClr   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            if ($urandom_range(0, 199) == 0) bus.irqEdge = 6'($urandom);
            if ($urandom_range(0, 15) == 0) bus.timerIrq = 1'($urandom);
            if ($urandom_range(0, 15) == 0) bus.swIP = 2'($urandom);
            if ($urandom_range(0, 49) == 0) bus.statusIM = 8'($urandom);
            bus.statusIE  = ($urandom_range(0, 9) != 0);
            bus.statusEXL = ($urandom_range(0, 19) == 0);
            bus.statusERL = ($urandom_range(0, 49) == 0);
            bus.intAck    = m_int && ($urandom_range(0, 3) == 0);
            step();
        end
        @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
